// File: rtl/common_pkg.sv
// Shared widths used across the pi switch fabric.
package common_pkg;

  parameter int unsigned DEFAULT_A_W = 8;
  parameter int unsigned DEFAULT_D_W = 16;

endpackage : common_pkg

// File: rtl/pi_input_vc_buffer_if.sv
// Upstream push / downstream switch-mux bundle for one pi switch input direction.
interface pi_input_vc_buffer_if #(
  parameter int unsigned A_W   = common_pkg::DEFAULT_A_W,
  parameter int unsigned D_W   = common_pkg::DEFAULT_D_W,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned W  = A_W + D_W + 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]         i_packet;
  logic                 i_vc;
  logic                 i_valid;
  logic [1:0]           o_ready_vc;
  logic [1:0][W-1:0]    o_vc_packet;
  logic [1:0]           o_vc_valid;
  logic                 o_which_vc;
  logic                 o_valid;
  logic                 i_grant;
  logic [1:0][CW-1:0]   o_count_vc;

  // Producer side: upstream link plus the switch grant.
  modport master (
    output i_packet, i_vc, i_valid, i_grant,
    input  o_ready_vc, o_vc_packet, o_vc_valid, o_which_vc, o_valid, o_count_vc
  );

  // Buffer side.
  modport slave (
    input  i_packet, i_vc, i_valid, i_grant,
    output o_ready_vc, o_vc_packet, o_vc_valid, o_which_vc, o_valid, o_count_vc
  );

endinterface : pi_input_vc_buffer_if

// File: rtl/pi_input_vc_buffer.sv
// Two-VC input buffer: one FIFO per VC, round-robin head selection, pop on grant.
module pi_input_vc_buffer #(
  parameter int unsigned A_W   = common_pkg::DEFAULT_A_W,
  parameter int unsigned D_W   = common_pkg::DEFAULT_D_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pi_input_vc_buffer_if.slave   bus
);

  localparam int unsigned W  = A_W + D_W + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]        mem [2][DEPTH];
  logic [1:0][PW-1:0]  wr_ptr;
  logic [1:0][PW-1:0]  rd_ptr;
  logic [1:0][CW-1:0]  count;
  logic                last_served;

  logic [1:0]          ready_c;
  logic [1:0]          nonempty_c;
  logic                which_c;
  logic                sel_valid_c;
  logic [1:0]          push_vc_c;
  logic [1:0]          pop_vc_c;
  logic [1:0][W-1:0]   head_c;

  // Per-VC status and heads, derived only from registered state.
  always_comb begin
    ready_c    = '0;
    nonempty_c = '0;
    head_c     = '0;
    for (int v = 0; v < 2; v++) begin
      ready_c[v]    = (count[v] != CW'(DEPTH));
      nonempty_c[v] = (count[v] != CW'(0));
      if (nonempty_c[v]) head_c[v] = mem[v][rd_ptr[v]];
    end
  end

  // Round-robin pick: alternate when both hold data, else take the one that does.
  always_comb begin
    which_c = ~last_served;
    if (nonempty_c == 2'b01)      which_c = 1'b0;
    else if (nonempty_c == 2'b10) which_c = 1'b1;
    sel_valid_c = which_c ? nonempty_c[1] : nonempty_c[0];
  end

  // Transfer qualification; a full VC refuses a push even while being popped.
  always_comb begin
    push_vc_c = '0;
    pop_vc_c  = '0;
    if (bus.i_valid && ready_c[bus.i_vc]) push_vc_c[bus.i_vc] = 1'b1;
    if (bus.i_grant && sel_valid_c)       pop_vc_c[which_c]   = 1'b1;
  end

  // Pointer, occupancy and arbitration history state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_served <= 1'b1;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (push_vc_c[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
        if (pop_vc_c[v])  rd_ptr[v] <= rd_ptr[v] + PW'(1);
        case ({push_vc_c[v], pop_vc_c[v]})
          2'b10:   count[v] <= count[v] + CW'(1);
          2'b01:   count[v] <= count[v] - CW'(1);
          default: count[v] <= count[v];
        endcase
      end
      if (bus.i_grant && sel_valid_c) last_served <= which_c;
    end
  end

  // Storage; contents are masked by occupancy so no reset is needed.
  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (push_vc_c[v]) mem[v][wr_ptr[v]] <= bus.i_packet;
    end
  end

  assign bus.o_ready_vc  = ready_c;
  assign bus.o_vc_valid  = nonempty_c;
  assign bus.o_vc_packet = head_c;
  assign bus.o_which_vc  = which_c;
  assign bus.o_valid     = sel_valid_c;
  assign bus.o_count_vc  = count;

endmodule : pi_input_vc_buffer

// File: tb/tb_pi_input_vc_buffer.sv
// Directed bench for pi_input_vc_buffer with a per-VC queue scoreboard.
module tb_pi_input_vc_buffer;

  localparam int unsigned A_W   = common_pkg::DEFAULT_A_W;
  localparam int unsigned D_W   = common_pkg::DEFAULT_D_W;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = A_W + D_W + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic         m_last;

  pi_input_vc_buffer_if #(.A_W(A_W), .D_W(D_W), .DEPTH(DEPTH)) bus ();

  pi_input_vc_buffer #(.A_W(A_W), .D_W(D_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_valid  = 1'b0;
    bus.i_vc     = 1'b0;
    bus.i_packet = '0;
    bus.i_grant  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    q0.delete();
    q1.delete();
    m_last = 1'b1;
  endtask

  // Compare all outputs against the queue model, then drive one cycle and advance the model.
  task automatic cyc(input logic v, input logic vc, input logic [W-1:0] pkt, input logic g);
    int           n0;
    int           n1;
    logic         ev0;
    logic         ev1;
    logic         ew;
    logic         eval;
    logic [W-1:0] h0;
    logic [W-1:0] h1;
    n0  = q0.size();
    n1  = q1.size();
    ev0 = (n0 != 0);
    ev1 = (n1 != 0);
    if (ev0 && !ev1)      ew = 1'b0;
    else if (ev1 && !ev0) ew = 1'b1;
    else                  ew = ~m_last;
    eval = ew ? ev1 : ev0;
    h0   = ev0 ? q0[0] : '0;
    h1   = ev1 ? q1[0] : '0;
    chk("o_valid",      64'(bus.o_valid),         64'(eval));
    chk("o_which_vc",   64'(bus.o_which_vc),      64'(ew));
    chk("o_vc_valid",   64'(bus.o_vc_valid),      64'({ev1, ev0}));
    chk("o_ready_vc",   64'(bus.o_ready_vc),      64'({n1 != int'(DEPTH), n0 != int'(DEPTH)}));
    chk("count0",       64'(bus.o_count_vc[0]),   64'(n0));
    chk("count1",       64'(bus.o_count_vc[1]),   64'(n1));
    chk("head0",        64'(bus.o_vc_packet[0]),  64'(h0));
    chk("head1",        64'(bus.o_vc_packet[1]),  64'(h1));
    bus.i_valid  = v;
    bus.i_vc     = vc;
    bus.i_packet = pkt;
    bus.i_grant  = g;
    if (g && eval) begin
      if (ew) void'(q1.pop_front());
      else    void'(q0.pop_front());
      m_last = ew;
    end
    if (v) begin
      if (!vc && n0 != int'(DEPTH)) q0.push_back(pkt);
      if (vc  && n1 != int'(DEPTH)) q1.push_back(pkt);
    end
    tick();
    bus.i_valid = 1'b0;
    bus.i_grant = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while ((q0.size() + q1.size()) != 0 && budget > 0) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      budget--;
    end
    chk("drain_budget", 64'(q0.size() + q1.size()), 64'(0));
    cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    m_last   = 1'b1;

    // Reset values
    do_reset();
    chk("rst_vc_valid", 64'(bus.o_vc_valid), 64'(2'b00));
    chk("rst_valid",    64'(bus.o_valid),    64'(0));
    chk("rst_ready",    64'(bus.o_ready_vc), 64'(2'b11));
    chk("rst_which",    64'(bus.o_which_vc), 64'(0));
    chk("rst_count",    64'(bus.o_count_vc), 64'(0));
    chk("rst_heads",    64'(bus.o_vc_packet), 64'(0));

    // Single push, visible one cycle later
    cyc(1'b1, 1'b0, W'(8'hA5), 1'b0);
    chk("t1_vc_valid", 64'(bus.o_vc_valid),     64'(2'b01));
    chk("t1_which",    64'(bus.o_which_vc),     64'(0));
    chk("t1_head0",    64'(bus.o_vc_packet[0]), 64'(8'hA5));
    chk("t1_count0",   64'(bus.o_count_vc[0]),  64'(1));
    drain();

    // Fill VC1, fifth push refused
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, W'(32'h100 + i), 1'b0);
    chk("full_ready", 64'(bus.o_ready_vc), 64'(2'b01));
    cyc(1'b1, 1'b1, W'(32'h1FF), 1'b0);
    chk("full_count1", 64'(bus.o_count_vc[1]), 64'(4));
    chk("full_head1",  64'(bus.o_vc_packet[1]), 64'(32'h100));
    drain();

    // Round-robin alternation from a fresh reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, W'(32'h200 + i), 1'b0);
      cyc(1'b1, 1'b1, W'(32'h300 + i), 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      chk("rr_seq", 64'(bus.o_which_vc), 64'(i % 2));
      cyc(1'b0, 1'b0, '0, 1'b1);
    end
    chk("rr_final_valid", 64'(bus.o_valid), 64'(0));

    // Push and pop same VC in one cycle
    cyc(1'b1, 1'b0, W'(32'h400), 1'b0);
    cyc(1'b1, 1'b0, W'(32'h401), 1'b1);
    chk("pp_count0", 64'(bus.o_count_vc[0]), 64'(1));
    chk("pp_head0",  64'(bus.o_vc_packet[0]), 64'(32'h401));
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, W'(32'h410 + i), 1'b0);
    chk("pp_full", 64'(bus.o_count_vc[0]), 64'(4));
    cyc(1'b1, 1'b0, W'(32'h4FF), 1'b1);
    chk("pp_refused_count", 64'(bus.o_count_vc[0]), 64'(3));
    drain();

    // Six packets through VC0 with interleaved grants, across the pointer wrap
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, W'(32'h500 + i), 1'(i % 2));
    // Independent push to VC1 while VC0 is popped
    cyc(1'b1, 1'b1, W'(32'h600), 1'b1);
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, W'(32'h700 + i), 1'b0);
      cyc(1'b1, 1'b1, W'(32'h710 + i), 1'b0);
    end
    chk("pre_rst_count", 64'(bus.o_count_vc), 64'({3'd2, 3'd2}));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vc_valid", 64'(bus.o_vc_valid),  64'(2'b00));
    chk("arst_valid",    64'(bus.o_valid),     64'(0));
    chk("arst_ready",    64'(bus.o_ready_vc),  64'(2'b11));
    chk("arst_count",    64'(bus.o_count_vc),  64'(0));
    chk("arst_heads",    64'(bus.o_vc_packet), 64'(0));
    chk("arst_which",    64'(bus.o_which_vc),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    q0.delete();
    q1.delete();
    m_last = 1'b1;
    cyc(1'b1, 1'b1, W'(32'h3C), 1'b0);
    chk("post_rst_head1", 64'(bus.o_vc_packet[1]), 64'(32'h3C));
    chk("post_rst_head0", 64'(bus.o_vc_packet[0]), 64'(0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pi_input_vc_buffer

// File: doc/pi_input_vc_buffer.md
Name: pi_input_vc_buffer

Overview:
- Per-input-direction virtual-channel buffer for the pi switch, with VC_W = 2.
- One instance sits upstream of each pi switch input direction (l, r, u0, u1).
- It holds one FIFO per VC and presents both VC heads in parallel to the switch's 2:1 input mux.
- It round-robin arbitrates between non-empty VCs, drives the mux select, and pops the selected head when the switch grants it.

Parameters:
- A_W, DEFAULT_A_W (common_pkg), address width.
- D_W, DEFAULT_D_W (common_pkg), data width. Packet width is W = A_W+D_W+1; the packet is treated as opaque.
- DEPTH, 4, entries per VC FIFO. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- i_packet  input  [A_W+D_W:0]  incoming packet.
- i_vc  input  1  VC that i_packet targets.
- i_valid  input  1  i_packet/i_vc valid.
- o_ready_vc  output  [1:0]  per-VC ready (FIFO not full).
- o_vc_packet  output  [1:0][A_W+D_W:0]  head entry of each VC FIFO; feeds the switch input mux data.
- o_vc_valid  output  [1:0]  per-VC FIFO non-empty.
- o_which_vc  output  1  arbitrated VC; feeds the switch input mux select.
- o_valid  output  1  selected head valid (= o_vc_valid[o_which_vc]).
- i_grant  input  1  switch consumed the selected head this cycle.
- o_count_vc  output  [1:0][$clog2(DEPTH):0]  per-VC occupancy, for credit/debug.

Behaviour:
- Reset (async assert, sync-safe deassert internal to clk domain):
  - All FIFOs empty: read/write pointers and counts are 0.
  - o_vc_valid = 2'b00, o_valid = 0, o_ready_vc = 2'b11.
  - o_count_vc = 0, o_vc_packet = 0.
  - Round-robin last-served register = 1, so VC0 wins first. o_which_vc = 0.
- Push: occurs when i_valid && o_ready_vc[i_vc]. The entry is written at FIFO[i_vc][wr_ptr], wr_ptr increments (wraps mod DEPTH), and count increments.
  - i_valid while o_ready_vc[i_vc] = 0 is not a transfer. Upstream holds the packet; nothing is written.
- o_ready_vc[v] = (count[v] != DEPTH). It comes from registered state only, with no combinational path from i_grant.
  - A full VC does not accept a push even in a cycle where it is popped (no bypass).
- No fall-through: a packet pushed in cycle N appears on o_vc_packet/o_vc_valid in cycle N+1. Minimum push-to-pop latency is 1 cycle.
- o_vc_packet[v] = FIFO[v][rd_ptr[v]] when count[v] != 0, else all zeros. Both heads are always driven, independent of arbitration.
- Arbitration, combinational from registered state:
  - Both VCs non-empty: o_which_vc = ~last_served.
  - Exactly one non-empty: o_which_vc = that VC.
  - Neither non-empty: o_which_vc = ~last_served, and o_valid = 0.
- Pop: occurs when i_grant && o_valid. FIFO[o_which_vc] rd_ptr increments (wraps), its count decrements, and last_served <= o_which_vc.
  - i_grant with o_valid = 0 is ignored: no state change.
- Simultaneous push and pop, same VC, not full: count is unchanged and both pointers advance.
  - A push to one VC and a pop of the other are independent.
- Counts never exceed DEPTH or go below 0 under any input sequence.
- Reset asserted mid-operation: all FIFOs are flushed immediately (asynchronously) and outputs return to reset values. Stored data is not preserved.

Test Plan:
- Reset, then push 0xA5 to VC0 at cycle 1 -> cycle 1: o_valid = 0. Cycle 2: o_vc_valid = 2'b01, o_which_vc = 0, o_vc_packet[0] = 0xA5, o_count_vc[0] = 1.
- Fill VC1 with 4 pushes (DEPTH = 4), no grants -> o_ready_vc = 2'b01 after the 4th. A 5th i_valid to VC1 is held and not written; count stays 4.
- Both VCs hold 3 entries, i_grant held high for 6 cycles -> o_which_vc sequence 0,1,0,1,0,1; both FIFOs drain in order; final o_valid = 0.
- VC0 holds 1 entry; push to VC0 and grant in the same cycle -> count stays 1, the new packet is at the head next cycle. The same with VC0 full -> push refused, count goes 4 to 3.
- Push 6 entries through VC0 with interleaved grants (pointer wrap at DEPTH = 4) -> packets exit in FIFO order; values match the scoreboard.
- Assert rst_n low mid-stream with 2 entries in each VC -> outputs go to reset values without waiting for clk. After release, the first push is delivered and the old data never reappears.
